// File: rtl/mips_boot_arbiter_pkg.sv
// Shared definitions for the mips boot arbiter: FSM state encoding.
package mips_boot_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_BOOT   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_e;
endpackage

// File: rtl/boot_addr_counter.sv
// Loadable, clearable WIDTH-bit counter that sticks at all-ones instead of wrapping.
module boot_addr_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_cnt
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] r_cnt;

  // Clear wins over load so a restart can never be masked by a load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_cnt <= '0;
    else if (i_clr)                      r_cnt <= '0;
    else if (i_load)                     r_cnt <= i_load_val;
    else if (i_inc && r_cnt != CNT_MAX)  r_cnt <= r_cnt + 1'b1;
  end

  assign o_cnt = r_cnt;
endmodule

// File: rtl/mips_boot_arbiter.sv
// Owns the byte-wide memory port: loader streams the image while the core is held
// in reset, then the core gets a combinational pass-through until the next reload.
module mips_boot_arbiter
  import mips_boot_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_valid,
  input  logic [WIDTH-1:0] ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  input  logic             reload,
  input  logic             cpu_memread,
  input  logic             cpu_memwrite,
  input  logic [WIDTH-1:0] cpu_adr,
  input  logic [WIDTH-1:0] cpu_writedata,
  output logic [WIDTH-1:0] cpu_memdata,
  output logic             cpu_rst,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wd,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [WIDTH-1:0] mem_rd,
  output logic             boot_done,
  output logic [WIDTH-1:0] load_count
);
  localparam logic [WIDTH-1:0] ADR_MAX = '1;

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] w_ld_addr;
  logic             w_xfer;
  logic             w_full;

  assign w_xfer = (r_state == ST_BOOT) && ld_valid;
  assign w_full = (w_ld_addr == ADR_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_INIT;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_INIT:   w_next = ST_BOOT;
      // A reload in the same cycle as the final byte restarts rather than finishing.
      ST_BOOT:   if (reload)                             w_next = ST_BOOT;
                 else if (w_xfer && (ld_last || w_full)) w_next = ST_SETTLE;
      ST_SETTLE: w_next = reload ? ST_BOOT : ST_RUN;
      ST_RUN:    if (reload) w_next = ST_BOOT;
      default:   w_next = ST_INIT;
    endcase
  end

  boot_addr_counter #(.WIDTH(WIDTH)) u_ld_addr (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (reload),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_xfer),
    .o_cnt      (w_ld_addr)
  );

  boot_addr_counter #(.WIDTH(WIDTH)) u_load_count (
    .clk        (clk),
    .rst_n      (rst),
    .i_clr      (reload),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_inc      (w_xfer),
    .o_cnt      (load_count)
  );

  // Core strobes reach memory only in RUN; otherwise the port idles unless a byte lands.
  always_comb begin
    mem_adr = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (r_state)
      ST_BOOT: if (w_xfer) begin
        mem_we  = 1'b1;
        mem_adr = w_ld_addr;
        mem_wd  = ld_data;
      end
      ST_RUN: begin
        mem_adr = cpu_adr;
        mem_wd  = cpu_writedata;
        mem_we  = cpu_memwrite;
        mem_re  = cpu_memread;
      end
      default: ;
    endcase
  end

  assign ld_ready    = (r_state == ST_BOOT);
  assign cpu_rst     = (r_state != ST_RUN);
  assign boot_done   = (r_state == ST_RUN);
  assign cpu_memdata = mem_rd;
endmodule

// File: tb/tb_mips_boot_arbiter.sv
// Scoreboard bench: expected memory writes are queued by stimulus and popped by a monitor.
module tb_mips_boot_arbiter;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ld_valid = 1'b0, ld_last = 1'b0, reload = 1'b0;
  logic [7:0] ld_data = '0;
  logic       cpu_memread = 1'b0, cpu_memwrite = 1'b0;
  logic [7:0] cpu_adr = '0, cpu_writedata = '0, mem_rd = '0;
  logic       ld_ready, cpu_rst, mem_we, mem_re, boot_done;
  logic [7:0] cpu_memdata, mem_adr, mem_wd, load_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  mips_boot_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
    .reload(reload),
    .cpu_memread(cpu_memread), .cpu_memwrite(cpu_memwrite),
    .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata), .cpu_memdata(cpu_memdata),
    .cpu_rst(cpu_rst),
    .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we), .mem_re(mem_re), .mem_rd(mem_rd),
    .boot_done(boot_done), .load_count(load_count)
  );

  // Monitor: every memory write must match the next queued expectation.
  always @(negedge clk) begin
    if (mem_we) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write adr=%02h wd=%02h (no write expected)", mem_adr, mem_wd);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if ({mem_adr, mem_wd} !== e) begin
          n_err++;
          $display("FAIL mem_write got adr=%02h wd=%02h expected adr=%02h wd=%02h",
                   mem_adr, mem_wd, e[15:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] adr, input logic [7:0] d, input logic last);
    ld_valid = 1'b1; ld_data = d; ld_last = last;
    exp_q.push_back({adr, d});
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic do_reload();
    reload = 1'b1;
    tick();
    reload = 1'b0;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cpu_rst", {7'd0, cpu_rst}, 8'd1);
    chk("rst_ld_ready", {7'd0, ld_ready}, 8'd0);
    chk("rst_boot_done", {7'd0, boot_done}, 8'd0);
    chk("rst_mem_we_re", {6'd0, mem_we, mem_re}, 8'd0);
    chk("rst_mem_adr", mem_adr, 8'h00);
    chk("rst_mem_wd", mem_wd, 8'h00);
    chk("rst_load_count", load_count, 8'h00);

    // INIT then BOOT; core strobes in BOOT must be ignored
    tick(); rst = 1'b1;
    chk("init_ld_ready", {7'd0, ld_ready}, 8'd0);
    cpu_memwrite = 1'b1; cpu_memread = 1'b1; cpu_adr = 8'h10; cpu_writedata = 8'h99;
    tick();
    chk("boot_ld_ready", {7'd0, ld_ready}, 8'd1);
    chk("boot_mem_re", {7'd0, mem_re}, 8'd0);
    cpu_memwrite = 1'b0; cpu_memread = 1'b0;

    // 3-byte image
    send(8'h00, 8'h20, 1'b0);
    send(8'h01, 8'h05, 1'b0);
    send(8'h02, 8'hFF, 1'b1);
    chk("settle_cpu_rst", {7'd0, cpu_rst}, 8'd1);
    chk("settle_ld_ready", {7'd0, ld_ready}, 8'd0);
    tick();
    chk("run_cpu_rst", {7'd0, cpu_rst}, 8'd0);
    chk("run_boot_done", {7'd0, boot_done}, 8'd1);
    chk("run_load_count", load_count, 8'd3);

    // RUN pass-through
    cpu_memwrite = 1'b1; cpu_adr = 8'h40; cpu_writedata = 8'hA5; mem_rd = 8'h3C;
    exp_q.push_back({8'h40, 8'hA5});
    #2;
    chk("run_cpu_memdata", cpu_memdata, 8'h3C);
    tick();
    cpu_memwrite = 1'b0; cpu_memread = 1'b1; cpu_adr = 8'h41;
    #2;
    chk("run_mem_re", {7'd0, mem_re}, 8'd1);
    chk("run_mem_adr", mem_adr, 8'h41);
    cpu_memread = 1'b0;
    tick();

    // Reload in RUN with a concurrent core write, then a 1-byte image
    cpu_memwrite = 1'b1; cpu_adr = 8'h42; cpu_writedata = 8'h5A;
    exp_q.push_back({8'h42, 8'h5A});
    do_reload();
    cpu_memwrite = 1'b0;
    chk("reload_cpu_rst", {7'd0, cpu_rst}, 8'd1);
    chk("reload_boot_done", {7'd0, boot_done}, 8'd0);
    chk("reload_load_count", load_count, 8'd0);
    send(8'h00, 8'h77, 1'b1);
    tick();
    chk("one_byte_run", {7'd0, boot_done}, 8'd1);
    chk("one_byte_count", load_count, 8'd1);

    // Gapped loader: 1,0,0,1(last)
    do_reload();
    send(8'h00, 8'h11, 1'b0);
    tick();
    chk("gap_ld_ready", {7'd0, ld_ready}, 8'd1);
    tick();
    send(8'h01, 8'h22, 1'b1);
    tick();
    chk("gap_count", load_count, 8'd2);

    // Full image, no ld_last: stops at 0xFF, 257th byte refused
    do_reload();
    for (int i = 0; i < 256; i++) send(i[7:0], i[7:0] ^ 8'h5A, 1'b0);
    ld_valid = 1'b1; ld_data = 8'hEE;
    #2;
    chk("full_ld_ready", {7'd0, ld_ready}, 8'd0);
    chk("full_count", load_count, 8'hFF);
    tick();
    ld_valid = 1'b0;
    chk("full_run", {7'd0, boot_done}, 8'd1);
    chk("full_count_hold", load_count, 8'hFF);

    // Reset mid-boot after 2 bytes
    do_reload();
    send(8'h00, 8'hA1, 1'b0);
    send(8'h01, 8'hA2, 1'b0);
    ld_valid = 1'b1; ld_data = 8'hA3; rst = 1'b0;
    #1;
    chk("abort_mem_we", {7'd0, mem_we}, 8'd0);
    chk("abort_cpu_rst", {7'd0, cpu_rst}, 8'd1);
    chk("abort_ld_ready", {7'd0, ld_ready}, 8'd0);
    chk("abort_mem_adr", mem_adr, 8'h00);
    chk("abort_count", load_count, 8'd0);
    tick(); rst = 1'b1;
    chk("rerst_init_ready", {7'd0, ld_ready}, 8'd0);
    ld_valid = 1'b0;
    tick();
    send(8'h00, 8'hB0, 1'b0);
    chk("rerst_count", load_count, 8'd1);

    // Reload coinciding with a transfer: write lands, counters still clear
    reload = 1'b1;
    send(8'h01, 8'hB1, 1'b0);
    reload = 1'b0;
    chk("reload_xfer_count", load_count, 8'd0);
    send(8'h00, 8'hB2, 1'b1);
    tick();
    chk("final_run", {7'd0, boot_done}, 8'd1);
    chk("final_count", load_count, 8'd1);

    tick();
    chk("queue_empty", exp_q.size() > 0 ? 8'd1 : 8'd0, 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mips_boot_arbiter.md
# mips_boot_arbiter

Owns the single byte-wide program/data memory port and sequences the `mips` core through boot. After reset it holds the core in reset and streams program bytes from a byte loader interface into memory at consecutive addresses. It then releases the core and hands it the memory port. A reload request returns ownership to the loader. The block sits between `mips` (its `memread`/`memwrite`/`adr`/`writedata`/`memdata`) and the memory macro.

## Interface
Parameters:
- `WIDTH`, 8: data and address width, matching the `mips` parameter.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `ld_valid`  in  1  loader byte valid.
- `ld_data`  in  WIDTH  loader byte.
- `ld_last`  in  1  marks the final byte of the image; qualified by `ld_valid`.
- `ld_ready`  out  1  block accepts a loader byte this cycle.
- `reload`  in  1  single-cycle pulse: restart the boot sequence.
- `cpu_memread`  in  1  core read strobe.
- `cpu_memwrite`  in  1  core write strobe.
- `cpu_adr`  in  WIDTH  core address.
- `cpu_writedata`  in  WIDTH  core write data.
- `cpu_memdata`  out  WIDTH  read data returned to the core.
- `cpu_rst`  out  1  active-high reset to `mips`.
- `mem_adr`  out  WIDTH  memory address.
- `mem_wd`  out  WIDTH  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_re`  out  1  memory read enable.
- `mem_rd`  in  WIDTH  memory read data.
- `boot_done`  out  1  high while the core owns memory.
- `load_count`  out  WIDTH  number of bytes written in the current or last boot; saturates at 2^WIDTH-1.

## Operation
- FSM states: INIT, BOOT, SETTLE, RUN. Registers: state, `ld_addr[WIDTH-1:0]`, `load_count`.
- Async reset (rst=0) forces:
  - state=INIT, `ld_addr`=0, `load_count`=0.
  - Outputs `cpu_rst`=1, `ld_ready`=0, `boot_done`=0, `mem_we`=0, `mem_re`=0, `mem_adr`=0, `mem_wd`=0.
- INIT: lasts one cycle, then goes to BOOT.
- BOOT:
  - `ld_ready`=1, `cpu_rst`=1.
  - A transfer occurs when `ld_valid`&`ld_ready`. On a transfer, the same cycle drives `mem_we`=1, `mem_adr`=`ld_addr`, `mem_wd`=`ld_data`. On that edge, `ld_addr`+1 and `load_count`+1.
  - A transfer with `ld_last`=1, or at `ld_addr`=2^WIDTH-1 (memory full), goes to SETTLE. At full, `ld_addr` does not wrap and further bytes are not accepted.
  - No transfer means no memory access.
  - `reload` in BOOT clears `ld_addr` and `load_count`, and state stays BOOT. If `reload` coincides with a transfer, the write occurs and the counters still clear.
- SETTLE:
  - Lasts one cycle: `ld_ready`=0, `cpu_rst`=1, no memory access. Then goes to RUN.
- RUN:
  - `cpu_rst`=0, `boot_done`=1, `ld_ready`=0.
  - Combinational pass-through: `mem_adr`=`cpu_adr`, `mem_wd`=`cpu_writedata`, `mem_we`=`cpu_memwrite`, `mem_re`=`cpu_memread`.
  - `cpu_memdata`=`mem_rd` in all states.
  - `reload`: next state BOOT, `ld_addr`/`load_count` cleared, `cpu_rst`=1 from the next cycle. A core write in the `reload` cycle still completes.
- Core strobes outside RUN are ignored.
- `load_count` holds its value through RUN until the next reload.

## Timing
- Loader throughput: 1 byte/cycle, zero-latency accept.
- Last loader byte in cycle N: SETTLE in N+1, RUN (`cpu_rst`=0) in N+2.
- Outputs `cpu_rst`, `boot_done`, `ld_ready` are decoded from registered state only.
- Memory-port outputs are combinational from state and inputs.
- Reset assertion mid-boot or mid-run aborts immediately, with no completion of the pending write.

## Structure
- Shared package: state encoding constants `ST_INIT`=2'd0, `ST_BOOT`=2'd1, `ST_SETTLE`=2'd2, `ST_RUN`=2'd3.
- One natural sub-module, `boot_addr_counter`: loadable, clearable, saturating WIDTH-bit counter, instantiated for `ld_addr` and for `load_count`.
- Memory mux and FSM live in the top.

## Test plan
- Reset release, 3 bytes 0x20,0x05,0xFF with `ld_last` on the third -> `mem_we` pulses at adr 0,1,2 with that data, `cpu_rst` falls 2 cycles after the third byte, `load_count`=3.
- Gapped `ld_valid` (1,0,0,1 and `ld_last`) -> exactly 2 writes at adr 0,1, no `mem_we` in gap cycles.
- RUN: core `cpu_memwrite`=1, adr 0x40, data 0xA5 -> `mem_we`=1, `mem_adr`=0x40, `mem_wd`=0xA5 same cycle. `mem_rd`=0x3C -> `cpu_memdata`=0x3C.
- Full image, 256 bytes with no `ld_last` -> last write at adr 0xFF, SETTLE follows, 257th byte not accepted (`ld_ready`=0), `load_count`=255.
- `reload` in RUN -> `cpu_rst`=1 and `boot_done`=0 next cycle. New 1-byte image written at adr 0.
- rst pulled low during BOOT after 2 bytes -> all outputs reach reset values immediately. After release: INIT then BOOT, writes restart at adr 0.
